// File: rtl/riscv_dmem_tcm.sv
// Tightly-coupled data memory responder with byte-lane masking, alignment and range checks,
// and a programmable number of wait states before the registered one-cycle acknowledge.
module riscv_dmem_tcm #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h1000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_req,
  input  logic [XLEN-1:0]   mem_adr,
  input  logic              mem_we,
  input  logic [XLEN/8-1:0] mem_be,
  input  logic [XLEN-1:0]   mem_d,
  output logic [XLEN-1:0]   mem_q,
  output logic              mem_ack,
  output logic              mem_misaligned,
  output logic              mem_page_fault,
  output logic              oob_err
);

  localparam int unsigned NB       = XLEN / 8;
  localparam int unsigned OffW     = $clog2(NB);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [XLEN-1:0] Base = BASE_ADDR[XLEN-1:0];
  localparam logic [3:0] WaitLoad  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   idx_q;
  logic            we_q;
  logic [NB-1:0]   be_q;
  logic [XLEN-1:0] d_q;
  logic            oob_q;

  logic [XLEN-1:0] mem [DEPTH];

  // Legal lane patterns: naturally aligned, contiguous runs of 1, 2, 4 (or 8) lanes.
  function automatic logic be_legal(input logic [NB-1:0] be);
    logic          ok;
    logic [NB-1:0] pat;
    ok = 1'b0;
    for (int unsigned p = 1; p <= NB; p = p * 2) begin
      for (int unsigned o = 0; o < NB; o = o + p) begin
        pat = NB'((1 << p) - 1) << o;
        if (be == pat) ok = 1'b1;
      end
    end
    return ok;
  endfunction

  logic [XLEN-1:0] offset;
  logic            in_rng;
  logic            be_ok;
  logic [AW-1:0]   in_idx;
  logic            acc_we;
  logic [NB-1:0]   acc_be;
  logic [XLEN-1:0] acc_d;
  logic [AW-1:0]   acc_idx;
  logic            commit;
  logic            wr_en;
  logic            rd_en;

  always_comb begin
    offset  = mem_adr - Base;
    in_rng  = (mem_adr >= Base) && ((offset >> (AW + OffW)) == '0);
    be_ok   = be_legal(mem_be);
    in_idx  = offset[AW+OffW-1:OffW];
    acc_we  = (state_q == StIdle) ? mem_we : we_q;
    acc_be  = (state_q == StIdle) ? mem_be : be_q;
    acc_d   = (state_q == StIdle) ? mem_d  : d_q;
    acc_idx = (state_q == StIdle) ? in_idx : idx_q;
    // Array access happens only on the edge that enters RESP with a legal, in-range access.
    commit  = ((state_q == StIdle) && mem_req && be_ok && in_rng && (WAIT_STATES == 0)) ||
              ((state_q == StWait) && (cnt_q == 4'd0) && !oob_q);
    wr_en   = commit && acc_we;
    rd_en   = commit && !acc_we;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_d[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      idx_q          <= '0;
      we_q           <= 1'b0;
      be_q           <= '0;
      d_q            <= '0;
      oob_q          <= 1'b0;
      mem_q          <= '0;
      mem_ack        <= 1'b0;
      mem_misaligned <= 1'b0;
      mem_page_fault <= 1'b0;
      oob_err        <= 1'b0;
    end else begin
      mem_q          <= '0;
      mem_ack        <= 1'b0;
      mem_misaligned <= 1'b0;
      mem_page_fault <= 1'b0;
      oob_err        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_req) begin
            idx_q <= in_idx;
            we_q  <= mem_we;
            be_q  <= mem_be;
            d_q   <= mem_d;
            oob_q <= !in_rng;
            if (!be_ok) begin
              state_q        <= StResp;
              mem_ack        <= 1'b1;
              mem_misaligned <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q <= StWait;
              cnt_q   <= WaitLoad;
            end else begin
              state_q <= StResp;
              mem_ack <= 1'b1;
              oob_err <= !in_rng;
              if (rd_en) mem_q <= mem[acc_idx];
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
            mem_ack <= 1'b1;
            oob_err <= oob_q;
            if (rd_en) mem_q <= mem[acc_idx];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem_tcm.sv
// Bench for riscv_dmem_tcm: three instances (0, 3 and 5 wait states) share the request
// attributes; each has its own request line and its own behavioural memory model.
module tb_riscv_dmem_tcm;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req [3];
  logic [31:0] adr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] d;
  logic [31:0] q [3];
  logic        ack [3];
  logic        mis [3];
  logic        pf [3];
  logic        oob [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] model [3][DEPTH];
  logic [3:0]  known [3][DEPTH];

  always #5 clk = ~clk;

  riscv_dmem_tcm #(.XLEN(32), .DEPTH(DEPTH), .BASE_ADDR(64'h1000_0000), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rstn(rstn), .mem_req(req[0]), .mem_adr(adr), .mem_we(we), .mem_be(be),
    .mem_d(d), .mem_q(q[0]), .mem_ack(ack[0]), .mem_misaligned(mis[0]),
    .mem_page_fault(pf[0]), .oob_err(oob[0]));
  riscv_dmem_tcm #(.XLEN(32), .DEPTH(DEPTH), .BASE_ADDR(64'h1000_0000), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rstn(rstn), .mem_req(req[1]), .mem_adr(adr), .mem_we(we), .mem_be(be),
    .mem_d(d), .mem_q(q[1]), .mem_ack(ack[1]), .mem_misaligned(mis[1]),
    .mem_page_fault(pf[1]), .oob_err(oob[1]));
  riscv_dmem_tcm #(.XLEN(32), .DEPTH(DEPTH), .BASE_ADDR(64'h1000_0000), .WAIT_STATES(5)) u_ws5 (
    .clk(clk), .rstn(rstn), .mem_req(req[2]), .mem_adr(adr), .mem_we(we), .mem_be(be),
    .mem_d(d), .mem_q(q[2]), .mem_ack(ack[2]), .mem_misaligned(mis[2]),
    .mem_page_fault(pf[2]), .oob_err(oob[2]));

  function automatic int ws_of(input int inst);
    return (inst == 0) ? 0 : (inst == 1) ? 3 : 5;
  endfunction

  // Lane pattern is legal when it is 1, 2 or 4 contiguous lanes starting on a multiple of its size.
  function automatic logic ref_legal(input logic [3:0] b);
    int pc;
    int lo;
    pc = $countones(b);
    if (!(pc == 1 || pc == 2 || pc == 4)) return 1'b0;
    lo = 0;
    for (int i = 3; i >= 0; i--) if (b[i]) lo = i;
    return ((lo % pc) == 0) && ((int'(b) >> lo) == ((1 << pc) - 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One full transaction on instance inst, starting just after a rising edge with the FSM idle.
  task automatic txn(input int inst, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] wd, input int drop_at, input string name,
                     output logic [31:0] got_q);
    logic        legal, inr, gotack;
    int          idx, lat, exp_lat;
    logic [31:0] exp_q, qmask, sq;
    logic        smis, soob, spf;
    legal   = ref_legal(b);
    inr     = (a >= BASE) && (a < BASE + DEPTH * 4);
    idx     = inr ? int'((a - BASE) / 4) : 0;
    exp_lat = legal ? 1 + ws_of(inst) : 1;
    exp_q   = 32'h0;
    qmask   = 32'hFFFF_FFFF;
    if (legal && inr && !w) begin
      exp_q = model[inst][idx];
      for (int i = 0; i < 4; i++) qmask[8*i +: 8] = {8{known[inst][idx][i]}};
    end
    adr = a; we = w; be = b; d = wd; req[inst] = 1'b1;
    gotack = 1'b0; lat = 0; sq = '0; smis = 1'b0; soob = 1'b0; spf = 1'b0;
    for (int k = 1; k <= 24 && !gotack; k++) begin
      @(posedge clk);
      #1;
      if (k == drop_at) req[inst] = 1'b0;
      @(negedge clk);
      if (ack[inst]) begin
        gotack = 1'b1; lat = k; sq = q[inst]; smis = mis[inst]; soob = oob[inst]; spf = pf[inst];
      end else if ((q[inst] | {31'b0, mis[inst]} | {31'b0, oob[inst]} | {31'b0, pf[inst]}) != 0) begin
        check({name, "_quiet"}, 32'h1, 32'h0);
      end
    end
    check({name, "_ack"}, {31'b0, gotack}, 32'h1);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_q"}, sq & qmask, exp_q & qmask);
    check({name, "_mis"}, {31'b0, smis}, {31'b0, !legal});
    check({name, "_oob"}, {31'b0, soob}, {31'b0, legal && !inr});
    check({name, "_pf"}, {31'b0, spf}, 32'h0);
    got_q = sq;
    if (legal && inr && w) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) begin
          model[inst][idx][8*i +: 8] = wd[8*i +: 8];
          known[inst][idx][i] = 1'b1;
        end
      end
    end
    // Request is still high through RESP; it must not start a second transaction.
    @(posedge clk);
    #1;
    req[inst] = 1'b0;
    @(negedge clk);
    check({name, "_noretrig"}, {31'b0, ack[inst]}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          inst;
    logic        w;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] wd;
    int          drop_at;
    logic        chk_q;
    logic [31:0] exp_q;
    string       name;
  } vec_t;

  vec_t vecs [$];
  logic [31:0] rq;

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        model[i][j] = '0;
        known[i][j] = '0;
      end
    end
    adr = '0; we = 1'b0; be = '0; d = '0;
    vecs = '{
      '{0, 1'b1, BASE + 8,  4'hF, 32'hDEAD_BEEF, 0, 1'b1, 32'h0,         "wr_deadbeef"},
      '{0, 1'b0, BASE + 8,  4'hF, 32'h0,         0, 1'b1, 32'hDEAD_BEEF, "rd_deadbeef"},
      '{0, 1'b1, BASE + 12, 4'hF, 32'h1122_3344, 0, 1'b0, 32'h0,         "wr_base_word"},
      '{0, 1'b1, BASE + 12, 4'h4, 32'h00AA_0000, 0, 1'b0, 32'h0,         "wr_byte2"},
      '{0, 1'b1, BASE + 13, 4'h3, 32'h0000_BBCC, 0, 1'b0, 32'h0,         "wr_half0"},
      '{0, 1'b0, BASE + 12, 4'hF, 32'h0,         0, 1'b1, 32'h11AA_BBCC, "rd_merged"},
      '{0, 1'b1, BASE + 12, 4'h6, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,         "mis_0110"},
      '{0, 1'b1, BASE + 12, 4'h7, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,         "mis_0111"},
      '{0, 1'b1, BASE + 12, 4'h0, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,         "mis_0000"},
      '{0, 1'b1, BASE + 12, 4'hE, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,         "mis_1110"},
      '{0, 1'b0, BASE + 12, 4'hF, 32'h0,         0, 1'b1, 32'h11AA_BBCC, "rd_after_mis"},
      '{0, 1'b1, BASE + 0,  4'hF, 32'h0101_0101, 0, 1'b0, 32'h0,         "wr_word0"},
      '{0, 1'b1, BASE + 60, 4'hF, 32'h0F0F_0F0F, 0, 1'b0, 32'h0,         "wr_wordlast"},
      '{0, 1'b0, BASE - 4,  4'hF, 32'h0,         0, 1'b1, 32'h0,         "oob_rd_below"},
      '{0, 1'b0, BASE + 64, 4'hF, 32'h0,         0, 1'b1, 32'h0,         "oob_rd_above"},
      '{0, 1'b1, BASE - 4,  4'hF, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,         "oob_wr_below"},
      '{0, 1'b1, BASE + 64, 4'hF, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,         "oob_wr_above"},
      '{0, 1'b0, BASE + 0,  4'hF, 32'h0,         0, 1'b1, 32'h0101_0101, "rd_word0"},
      '{0, 1'b0, BASE + 60, 4'hF, 32'h0,         0, 1'b1, 32'h0F0F_0F0F, "rd_wordlast"},
      '{1, 1'b1, BASE + 4,  4'h6, 32'hFFFF_FFFF, 0, 1'b1, 32'h0,         "ws3_mis"},
      '{1, 1'b1, BASE + 4,  4'hF, 32'h1234_5678, 0, 1'b1, 32'h0,         "ws3_wr"},
      '{1, 1'b0, BASE + 4,  4'hF, 32'h0,         2, 1'b1, 32'h1234_5678, "ws3_rd_drop"},
      '{1, 1'b0, BASE + 64, 4'hF, 32'h0,         0, 1'b1, 32'h0,         "ws3_oob"},
      '{2, 1'b1, BASE + 12, 4'hF, 32'h0,         0, 1'b1, 32'h0,         "ws5_clear"}
    };

    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_out%0d", i),
            {ack[i], mis[i], pf[i], oob[i], 28'b0} | q[i], 32'h0);
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[v]) begin
      txn(vecs[v].inst, vecs[v].w, vecs[v].a, vecs[v].b, vecs[v].wd, vecs[v].drop_at,
          vecs[v].name, rq);
      if (vecs[v].chk_q) check({vecs[v].name, "_tbl"}, rq, vecs[v].exp_q);
    end

    // Reset in the middle of a wait-stated write: the write must never land.
    adr = BASE + 12; we = 1'b1; be = 4'hF; d = 32'hCAFE_F00D; req[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    req[2] = 1'b0;
    #1;
    check("rst_mid_out", {ack[2], mis[2], pf[2], oob[2], 28'b0} | q[2], 32'h0);
    @(posedge clk);
    #1;
    check("rst_mid_held", {31'b0, ack[2]}, 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    txn(2, 1'b0, BASE + 12, 4'hF, 32'h0, 0, "rst_mid_rd", rq);
    check("rst_mid_rd_tbl", rq, 32'h0);

    // Randomised traffic against the model on the 0- and 3-wait-state instances.
    for (int n = 0; n < 120; n++) begin
      int          inst;
      logic [31:0] a;
      inst = n % 2;
      a = BASE - 8 + $urandom_range(0, DEPTH * 4 + 15);
      txn(inst, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, 0,
          $sformatf("rnd%0d", n), rq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_tcm.md
# riscv_dmem_tcm

Tightly-coupled data memory that terminates the core's data memory access bus as the responder: it accepts `mem_req` transactions, performs byte-lane-masked reads and writes against an internal word-organised array, and returns `mem_q`, `mem_ack`, `mem_misaligned` and `mem_page_fault`. It sits directly on the core's data port with no cache or MMU in between. Latency is programmable by wait states so the bench and SoC can model slower memories.

## Interface

- `XLEN`, 32: data/address width; 32 or 64 only.
- `DEPTH`, 1024: number of XLEN-bit words; power of two, ≥2.
- `BASE_ADDR`, 'h1000_0000: byte address of word 0; aligned to DEPTH*XLEN/8.
- `WAIT_STATES`, 0: extra cycles inserted before `mem_ack`; 0..15.

- `rstn`  in  1  asynchronous active-low reset.
- `clk`  in  1  clock; all state updates on its rising edge.
- `mem_req`  in  1  request valid; held with attributes until `mem_ack`.
- `mem_adr`  in  XLEN  byte address.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_be`  in  XLEN/8  byte-lane enables.
- `mem_d`  in  XLEN  write data, lane-aligned.
- `mem_q`  out  XLEN  read data; valid only while `mem_ack`=1.
- `mem_ack`  out  1  one-cycle completion strobe.
- `mem_misaligned`  out  1  qualifies `mem_ack`: access rejected.
- `mem_page_fault`  out  1  always 0 (no translation); registered.
- `oob_err`  out  1  qualifies `mem_ack`: address outside the array.

## Operation

- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: if `mem_req`=1, capture `mem_adr`, `mem_we`, `mem_be`, `mem_d`; classify; go to WAIT when WAIT_STATES>0 and access legal, else RESP. Wait counter loads WAIT_STATES-1.
- WAIT: counter decrements each cycle; at 0 go to RESP. `mem_req` is not re-sampled; dropping it mid-transaction does not abort.
- RESP: `mem_ack`=1 for exactly one cycle; always returns to IDLE. `mem_req` seen during RESP belongs to the completing transaction and is ignored.
- Classification (on captured values, priority order):
  - Misaligned: `mem_be` not a legal pattern. Legal = popcount in {1,2,4,8 (XLEN=64 only)}, lanes contiguous, lowest lane index a multiple of popcount. `mem_be`=0 is misaligned. Goes straight to RESP regardless of WAIT_STATES; no array access; `mem_misaligned`=1, `mem_q`=0.
  - Out of range: `mem_adr` < BASE_ADDR or ≥ BASE_ADDR+DEPTH*XLEN/8. Full wait-state latency; write dropped; `mem_q`=0; `oob_err`=1 with ack.
  - Legal: index = (`mem_adr`-BASE_ADDR) >> log2(XLEN/8); low address bits ignored (lanes come from `mem_be`).
- Write commits on the edge entering RESP, only enabled lanes updated; `mem_q`=0 on write ack.
- Read: `mem_q` = full stored word (all lanes) at the indexed location, sampled on the edge entering RESP.
- `mem_page_fault`, `mem_misaligned`, `oob_err`, `mem_q` are 0 whenever `mem_ack`=0.

## Timing

- Reset: all outputs 0, FSM IDLE, counter 0; array contents not initialised and not cleared. Reset during WAIT abandons the transaction; pending write never commits.
- Request first seen in IDLE in cycle T → `mem_ack` in cycle T+1+WAIT_STATES (misaligned: T+1).
- Throughput: one transaction per 2+WAIT_STATES cycles; earliest next acceptance is the cycle after RESP.
- Read-after-write to same word in consecutive transactions returns the new data (no hazard).
- All outputs registered; no combinational path from inputs to outputs.

## Test plan

- Reset then read-write-read: WAIT_STATES=0, write `mem_d`='hDEADBEEF, be=1111 at BASE_ADDR+8 → ack at T+1; read same → `mem_q`='hDEADBEEF at T+1, next acceptance no earlier than T+2.
- Byte/half masking: word = 'h11223344; write be=0100 d='h00AA0000, then be=0011 d='h0000BBCC → read returns 'h11AABBCC.
- Misalignment: be=0110, 0111, 0000, 1110 each → ack next cycle, `mem_misaligned`=1, `mem_q`=0, array unchanged; with WAIT_STATES=3 still T+1.
- Out of range: read BASE_ADDR-4 and BASE_ADDR+DEPTH*4 → ack at normal latency, `oob_err`=1, `mem_q`=0; write there leaves word 0 and word DEPTH-1 unchanged.
- Wait states: WAIT_STATES=3, read → ack at T+4; drop `mem_req` at T+2 → ack still at T+4 with captured data.
- Reset mid-write: WAIT_STATES=5, write 'hCAFEF00D to a word holding 'h0, assert `rstn`=0 at T+3 → outputs 0 immediately, FSM IDLE; subsequent read returns 'h0.
